// File: rtl/pwm_deadtime_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_deadtime_pkg: shared state encoding and constants for dead time   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package pwm_deadtime_pkg;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_DEAD = 2'd1,
    S_HS   = 2'd2,
    S_LS   = 2'd3
  } t_dt_state;

  localparam int c_dt_min = 1;

  // Number of cycles both outputs stay low for a programmed dead time.
  function automatic int f_gap(input int dt);
    return (dt < c_dt_min) ? c_dt_min : dt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_deadtime_gen_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_deadtime_gen_if: control inputs and gate-drive outputs bundle     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface pwm_deadtime_gen_if #(
  parameter int g_num_channels = 8,
  parameter int g_dt_width     = 8
);
  logic                      en_i;
  logic [g_dt_width-1:0]     dt_i;
  logic                      kill_i;
  logic [g_num_channels-1:0] pwm_i;
  logic [g_num_channels-1:0] pwm_hs_o;
  logic [g_num_channels-1:0] pwm_ls_o;
  logic                      fault_o;

  modport master (
    output en_i, dt_i, kill_i, pwm_i,
    input  pwm_hs_o, pwm_ls_o, fault_o
  );

  modport slave (
    input  en_i, dt_i, kill_i, pwm_i,
    output pwm_hs_o, pwm_ls_o, fault_o
  );
endinterface
`default_nettype wire

// File: rtl/pwm_deadtime_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_deadtime_ch: one complementary channel with break-before-make gap |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pwm_deadtime_ch
  import pwm_deadtime_pkg::*;
#(
  parameter int g_dt_width = 8
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_n_i,
  input  logic                  force_i,
  input  logic [g_dt_width-1:0] dt_i,
  input  logic                  pwm_i,
  output logic                  pwm_hs_o,
  output logic                  pwm_ls_o
);

  localparam logic [g_dt_width-1:0] c_cnt_min = g_dt_width'(c_dt_min);

  t_dt_state             state_q, state_d;
  logic [g_dt_width-1:0] cnt_q, cnt_d;
  logic                  pwm_q;
  logic                  hs_q, hs_d;
  logic                  ls_q, ls_d;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      pwm_q   <= 1'b0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_i;
      hs_q    <= hs_d;
      ls_q    <= ls_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (force_i) begin
      state_d = S_OFF;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_DEAD;
          cnt_d   = dt_i;
        end
        S_HS: begin
          if (!pwm_q) begin
            state_d = S_DEAD;
            cnt_d   = dt_i;
          end
        end
        S_LS: begin
          if (pwm_q) begin
            state_d = S_DEAD;
            cnt_d   = dt_i;
          end
        end
        S_DEAD: begin
          // Exit target follows pwm_q at exit time, so short pulses vanish.
          if (cnt_q <= c_cnt_min) begin
            state_d = pwm_q ? S_HS : S_LS;
          end else begin
            cnt_d = cnt_q - c_cnt_min;
          end
        end
        default: state_d = S_OFF;
      endcase
    end
    hs_d = (state_d == S_HS);
    ls_d = (state_d == S_LS);
  end

  assign pwm_hs_o = hs_q;
  assign pwm_ls_o = ls_q;

endmodule
`default_nettype wire

// File: rtl/pwm_deadtime_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pwm_deadtime_gen: fault latch, force-off and per-channel dead time    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pwm_deadtime_gen
  import pwm_deadtime_pkg::*;
#(
  parameter int g_num_channels = 8,
  parameter int g_dt_width     = 8
) (
  input  logic               clk_sys_i,
  input  logic               rst_n_i,
  pwm_deadtime_gen_if.slave  bus
);

  logic                      fault_q, fault_d;
  logic                      force_w;
  logic [g_num_channels-1:0] hs_w;
  logic [g_num_channels-1:0] ls_w;

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  // A kill in the same cycle as a disable keeps the latch set.
  always_comb begin
    fault_d = fault_q;
    if (bus.kill_i) begin
      fault_d = 1'b1;
    end else if (!bus.en_i) begin
      fault_d = 1'b0;
    end
  end

  assign force_w = ~bus.en_i | bus.kill_i | fault_q;

  for (genvar g = 0; g < g_num_channels; g++) begin : g_ch
    pwm_deadtime_ch #(
      .g_dt_width (g_dt_width)
    ) u_ch (
      .clk_sys_i (clk_sys_i),
      .rst_n_i   (rst_n_i),
      .force_i   (force_w),
      .dt_i      (bus.dt_i),
      .pwm_i     (bus.pwm_i[g]),
      .pwm_hs_o  (hs_w[g]),
      .pwm_ls_o  (ls_w[g])
    );
  end

  assign bus.pwm_hs_o = hs_w;
  assign bus.pwm_ls_o = ls_w;
  assign bus.fault_o  = fault_q;

  a_no_overlap: assert property (@(posedge clk_sys_i) (hs_w & ls_w) == '0);

endmodule
`default_nettype wire

// File: tb/tb_pwm_deadtime_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pwm_deadtime_gen: directed stimulus with output-change scoreboard  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_pwm_deadtime_gen;
  import pwm_deadtime_pkg::*;

  typedef struct {
    int         cyc;
    logic       fault;
    logic [7:0] hs;
    logic [7:0] ls;
  } ev_t;

  logic clk_sys_i = 1'b0;
  logic rst_n_i   = 1'b0;
  int   total     = 0;
  int   bad       = 0;
  int   cyc       = 0;
  bit   mon_en    = 1'b0;
  ev_t  sb[$];

  pwm_deadtime_gen_if #(.g_num_channels(8), .g_dt_width(8)) bus ();

  pwm_deadtime_gen #(
    .g_num_channels (8),
    .g_dt_width     (8)
  ) dut (
    .clk_sys_i (clk_sys_i),
    .rst_n_i   (rst_n_i),
    .bus       (bus.slave)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

  // Monitor: samples 1ns after each rising edge; any output change pops one event.
  logic [16:0] prev_v = '0;
  always @(posedge clk_sys_i) begin
    logic [16:0] cur_v;
    ev_t         e;
    #1;
    cyc++;
    cur_v = {bus.fault_o, bus.pwm_hs_o, bus.pwm_ls_o};
    if (mon_en) begin
      total++;
      if ((bus.pwm_hs_o & bus.pwm_ls_o) != 8'h00) begin
        bad++;
        $display("FAIL overlap: cyc=%0d hs=%h ls=%h, required hs&ls=00", cyc, bus.pwm_hs_o, bus.pwm_ls_o);
      end
      if (cur_v != prev_v) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change: cyc=%0d f=%0b hs=%h ls=%h, required no change",
                   cyc, bus.fault_o, bus.pwm_hs_o, bus.pwm_ls_o);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.fault != bus.fault_o || e.hs != bus.pwm_hs_o || e.ls != bus.pwm_ls_o) begin
            bad++;
            $display("FAIL event: got cyc=%0d f=%0b hs=%h ls=%h, required cyc=%0d f=%0b hs=%h ls=%h",
                     cyc, bus.fault_o, bus.pwm_hs_o, bus.pwm_ls_o, e.cyc, e.fault, e.hs, e.ls);
          end
        end
      end
    end
    prev_v = cur_v;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_sys_i);
  endtask

  task automatic push(input int c, input logic f, input logic [7:0] hs, input logic [7:0] ls);
    ev_t e;
    e.cyc = c; e.fault = f; e.hs = hs; e.ls = ls;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Drive a new pwm pattern with given dt; channels whose level flips leave their
  // active output after E1 and enter the opposite one after E(1+gap).
  task automatic transition(input logic [7:0] pwm, input logic [7:0] dt,
                            input logic [7:0] hs_before,
                            input logic [7:0] hs_after);
    int base;
    base        = cyc;
    bus.pwm_i   = pwm;
    bus.dt_i    = dt;
    push(base + 2, 1'b0, hs_before & hs_after, ~hs_before & ~hs_after);
    push(base + 2 + f_gap(int'(dt)), 1'b0, hs_after, ~hs_after);
  endtask

  initial begin
    int base;
    bus.en_i   = 1'b1;
    bus.dt_i   = 8'd4;
    bus.kill_i = 1'b0;
    bus.pwm_i  = 8'h00;

    // Reset state
    step(3);
    check("reset_hs", bus.pwm_hs_o, 8'h00);
    check("reset_ls", bus.pwm_ls_o, 8'h00);
    check("reset_fault", {7'd0, bus.fault_o}, 8'h00);
    mon_en = 1'b1;

    // Release: first enable passes through one dead gap before low side
    base    = cyc;
    rst_n_i = 1'b1;
    push(base + 1 + f_gap(4), 1'b0, 8'h00, 8'hFF);
    step(8);

    // dt=4 edges both directions
    transition(8'hFF, 8'd4, 8'h00, 8'hFF);
    step(8);
    transition(8'h00, 8'd4, 8'hFF, 8'h00);
    step(8);

    // dt=0 still gives a 1-cycle gap, toggling every 3 cycles
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) transition(8'hFF, 8'd0, 8'h00, 8'hFF);
      else            transition(8'h00, 8'd0, 8'hFF, 8'h00);
      step(3);
    end
    step(3);

    // dt=6, 2-cycle high pulse is swallowed: ls low 6 cycles, hs never set
    base        = cyc;
    bus.dt_i    = 8'd6;
    bus.pwm_i   = 8'hFF;
    push(base + 2, 1'b0, 8'h00, 8'h00);
    push(base + 2 + f_gap(6), 1'b0, 8'h00, 8'hFF);
    step(2);
    bus.pwm_i   = 8'h00;
    step(10);

    // Mixed pattern: low nibble high side, high nibble low side
    transition(8'h0F, 8'd2, 8'h00, 8'h0F);
    step(8);

    // One-cycle kill: immediate off, fault latched
    base       = cyc;
    bus.kill_i = 1'b1;
    push(base + 1, 1'b1, 8'h00, 8'h00);
    step(1);
    bus.kill_i = 1'b0;
    step(4);
    check("fault_sticky", {7'd0, bus.fault_o}, 8'h01);
    check("kill_hs_off", bus.pwm_hs_o, 8'h00);

    // One cycle of disable clears the latch; re-enable resumes after a dt gap
    base       = cyc;
    bus.en_i   = 1'b0;
    push(base + 1, 1'b0, 8'h00, 8'h00);
    step(1);
    base       = cyc;
    bus.en_i   = 1'b1;
    push(base + 1 + f_gap(2), 1'b0, 8'h0F, 8'hF0);
    step(6);
    check("fault_cleared", {7'd0, bus.fault_o}, 8'h00);

    // Max dt; changing dt mid-gap does not shorten the current gap
    transition(8'h00, 8'd255, 8'h0F, 8'h00);
    step(10);
    bus.dt_i = 8'd2;
    step(250);
    transition(8'h0F, 8'd2, 8'h00, 8'h0F);
    step(8);

    // Async reset mid-gap drops outputs at once, then restart via S_OFF
    transition(8'h00, 8'd20, 8'h0F, 8'h00);
    sb.pop_back();
    step(5);
    #2;
    rst_n_i = 1'b0;
    push(cyc + 1, 1'b0, 8'h00, 8'h00);
    #1;
    check("async_rst_hs", bus.pwm_hs_o, 8'h00);
    check("async_rst_ls", bus.pwm_ls_o, 8'h00);
    step(2);
    base    = cyc;
    rst_n_i = 1'b1;
    push(base + 1 + f_gap(20), 1'b0, 8'h00, 8'hFF);
    step(25);

    step(2);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d events still pending, required 0 (next cyc=%0d)", sb.size(), sb[0].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
